// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-PC source encodings,
// instruction stride and an alignment helper.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_SEL_SEQ = 2'b00,
    PC_SEL_REL = 2'b01,
    PC_SEL_IND = 2'b10,
    PC_SEL_RET = 2'b11
  } pc_sel_e;

  localparam int unsigned PC_STRIDE = 4;

  function automatic logic is_word_aligned(input logic [1:0] lsbs);
    return (lsbs == 2'b00);
  endfunction

endpackage

// File: rtl/return_address_stack.sv
// Circular return-address stack. ptr addresses the current top entry; count
// tracks how many entries are live. A push onto a full stack overwrites the
// oldest entry and leaves count saturated. Push and pop in the same cycle
// replace the top entry in place.
module return_address_stack #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]   ptr;
  logic [CW-1:0]   count;
  logic            do_pop;
  logic [PW-1:0]   wr_ptr;

  assign do_pop = pop & (count != '0);

  // Write slot: replace the top when popping in the same cycle, else the next slot.
  always_comb begin
    wr_ptr = ptr + PW'(1);
    if (do_pop) wr_ptr = ptr;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= wr_ptr;
      if (!do_pop && (count != CW'(RAS_DEPTH))) count <= count + CW'(1);
    end else if (do_pop) begin
      ptr   <= ptr - PW'(1);
      count <= count - CW'(1);
    end
  end

  // Entry storage; contents are don't-care while count is zero, so no reset.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign top   = mem[ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/module_pc_unit.sv
// Program counter: holds the fetch address, picks the next PC from
// sequential, PC-relative, register-indirect or predicted-return sources and
// advances only on an accepted, unstalled fetch. A misaligned target freezes
// the PC and raises a sticky flag until reset.
module module_pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_ADDR = '0,
  parameter int              RAS_DEPTH  = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            is_jmp,
  input  logic            alu_not,
  input  logic [1:0]      is_branch,
  input  logic            is_call,
  input  logic            is_ret,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] imm,
  input  logic            imem_ready,
  output logic [XLEN-1:0] addr,
  output logic            imem_valid,
  output logic [XLEN-1:0] link,
  output logic            misaligned,
  output logic            ras_empty
);

  logic            taken;
  pc_sel_e         sel;
  logic [XLEN-1:0] ind_target;
  logic [XLEN-1:0] ras_top;
  logic [XLEN-1:0] next_pc;
  logic            next_misaligned;
  logic            advance;
  logic            ras_push;
  logic            ras_pop;

  assign link       = addr + XLEN'(PC_STRIDE);
  assign ind_target = {alu_out[XLEN-1:1], 1'b0};

  // Source select: conditional branches derive it from the ALU result.
  always_comb begin
    taken = alu_not ? (alu_out == '0) : (alu_out != '0);
    sel   = pc_sel_e'(is_branch);
    if (is_jmp) sel = pc_sel_e'({1'b0, taken});
  end

  // Next-PC mux; a return falls back to the indirect target when the RAS is empty.
  always_comb begin
    next_pc = link;
    case (sel)
      PC_SEL_SEQ: next_pc = link;
      PC_SEL_REL: next_pc = addr + imm;
      PC_SEL_IND: next_pc = ind_target;
      PC_SEL_RET: next_pc = ras_empty ? ind_target : ras_top;
      default:    next_pc = link;
    endcase
  end

  assign next_misaligned = !is_word_aligned(next_pc[1:0]);
  assign advance         = imem_valid & imem_ready & ~stall & ~misaligned;
  assign ras_push        = advance & ~next_misaligned & is_call;
  assign ras_pop         = advance & ~next_misaligned & is_ret & ~ras_empty;

  // Fetch address, request valid and sticky misalignment flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr       <= RESET_ADDR;
      imem_valid <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      imem_valid <= 1'b1;
      if (advance) begin
        if (next_misaligned) misaligned <= 1'b1;
        else                 addr       <= next_pc;
      end
    end
  end

  return_address_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (link),
    .top       (ras_top),
    .empty     (ras_empty)
  );

endmodule

// File: tb/tb_module_pc_unit.sv
// Bench for module_pc_unit: a queue-based reference model predicts the state
// after each edge; a monitor pops predictions and compares them to the DUT.
module tb_module_pc_unit;

  localparam int          XLEN   = 32;
  localparam logic [31:0] RST_PC = 32'h100;
  localparam int          DEPTH  = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall, is_jmp, alu_not, is_call, is_ret, imem_ready;
  logic [1:0]  is_branch;
  logic [31:0] alu_out, imm;
  logic [31:0] addr, link;
  logic        imem_valid, misaligned, ras_empty;

  module_pc_unit #(
    .XLEN       (XLEN),
    .RESET_ADDR (RST_PC),
    .RAS_DEPTH  (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .stall      (stall),
    .is_jmp     (is_jmp),
    .alu_not    (alu_not),
    .is_branch  (is_branch),
    .is_call    (is_call),
    .is_ret     (is_ret),
    .alu_out    (alu_out),
    .imm        (imm),
    .imem_ready (imem_ready),
    .addr       (addr),
    .imem_valid (imem_valid),
    .link       (link),
    .misaligned (misaligned),
    .ras_empty  (ras_empty)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic        valid;
    logic        mis;
    logic        empty;
  } exp_t;

  exp_t        sb[$];
  int          n_vec  = 0;
  int          n_fail = 0;

  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_mis;
  logic [31:0] m_ras[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkb(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_pc    = RST_PC;
    m_valid = 1'b0;
    m_mis   = 1'b0;
    m_ras.delete();
  endfunction

  // Reference behaviour: RAS is a plain list, newest at the back, oldest dropped when over depth.
  function automatic void model_step();
    logic [31:0] tgt;
    logic [1:0]  s;
    logic        tk;
    if (!m_valid) begin
      m_valid = 1'b1;
      return;
    end
    if (!imem_ready || stall || m_mis) return;
    tk = alu_not ? (alu_out == 32'd0) : (alu_out != 32'd0);
    s  = is_jmp ? {1'b0, tk} : is_branch;
    case (s)
      2'd0:    tgt = m_pc + 32'd4;
      2'd1:    tgt = m_pc + imm;
      2'd2:    tgt = alu_out & ~32'd1;
      default: tgt = (m_ras.size() > 0) ? m_ras[$] : (alu_out & ~32'd1);
    endcase
    if ((tgt % 4) != 0) begin
      m_mis = 1'b1;
      return;
    end
    if (is_ret && m_ras.size() > 0) void'(m_ras.pop_back());
    if (is_call) begin
      m_ras.push_back(m_pc + 32'd4);
      if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
    end
    m_pc = tgt;
  endfunction

  // Called at a falling edge: apply inputs, predict, and wait for the next falling edge.
  task automatic drive(input logic st, input logic rdy, input logic jmp, input logic an,
                       input logic [1:0] br, input logic cl, input logic rt,
                       input logic [31:0] alu, input logic [31:0] im);
    exp_t e;
    stall      = st;
    imem_ready = rdy;
    is_jmp     = jmp;
    alu_not    = an;
    is_branch  = br;
    is_call    = cl;
    is_ret     = rt;
    alu_out    = alu;
    imm        = im;
    model_step();
    e.addr  = m_pc;
    e.valid = m_valid;
    e.mis   = m_mis;
    e.empty = (m_ras.size() == 0);
    sb.push_back(e);
    @(negedge clock);
  endtask

  task automatic seq_step();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic jump_to(input logic [31:0] tgt);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, tgt, 32'd0);
  endtask

  // Called at a falling edge; asserts reset between edges and checks it takes effect at once.
  task automatic do_reset();
    #3;
    reset = 1'b1;
    #1;
    check("rst_addr", addr, RST_PC);
    checkb("rst_valid", imem_valid, 1'b0);
    checkb("rst_mis", misaligned, 1'b0);
    checkb("rst_empty", ras_empty, 1'b1);
    sb.delete();
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Monitor: compare DUT state just after each edge against the oldest prediction.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("mon_addr", addr, e.addr);
      checkb("mon_valid", imem_valid, e.valid);
      checkb("mon_mis", misaligned, e.mis);
      checkb("mon_empty", ras_empty, e.empty);
      check("mon_link", link, e.addr + 32'd4);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors, %0d miscompares", n_vec, n_fail);
    $fatal(1, "watchdog");
  end

  logic [31:0] call_exp [5];
  logic [31:0] ret_exp  [5];

  initial begin
    stall = 0; is_jmp = 0; alu_not = 0; is_branch = 0; is_call = 0; is_ret = 0;
    alu_out = 0; imm = 0; imem_ready = 1;
    call_exp = '{32'h140, 32'h180, 32'h1C0, 32'h200, 32'h240};
    ret_exp  = '{32'h204, 32'h1C4, 32'h184, 32'h144, 32'h300};

    @(negedge clock);
    do_reset();

    // Reset release and sequential fetch
    check("t1_reset_addr", addr, 32'h100);
    seq_step(); check("t1_a0", addr, 32'h100); checkb("t1_valid", imem_valid, 1'b1);
    seq_step(); check("t1_a1", addr, 32'h104);
    seq_step(); check("t1_a2", addr, 32'h108);

    // Conditional branch taken / not taken
    jump_to(32'h200); check("t2_jump", addr, 32'h200);
    drive(0, 1, 1, 1, 2'b00, 0, 0, 32'd0, 32'h20); check("t2_taken", addr, 32'h220);
    jump_to(32'h200);
    drive(0, 1, 1, 1, 2'b00, 0, 0, 32'd5, 32'h20); check("t2_not_taken", addr, 32'h204);

    // Stall and not-ready both hold the address
    jump_to(32'h40);
    drive(1, 1, 0, 0, 2'b00, 0, 0, 0, 0); check("t3_stall0", addr, 32'h40);
    drive(1, 1, 0, 0, 2'b00, 0, 0, 0, 0); check("t3_stall1", addr, 32'h40);
    drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0); check("t3_notready", addr, 32'h40);
    seq_step(); check("t3_release", addr, 32'h44);

    // Nested call / return
    do_reset();
    seq_step();
    jump_to(32'h10);
    drive(0, 1, 0, 0, 2'b01, 1, 0, 0, 32'h100); check("t4_call0", addr, 32'h110);
    drive(0, 1, 0, 0, 2'b01, 1, 0, 0, 32'h100); check("t4_call1", addr, 32'h210);
    drive(0, 1, 0, 0, 2'b11, 0, 1, 0, 0);       check("t4_ret0", addr, 32'h114);
    drive(0, 1, 0, 0, 2'b11, 0, 1, 0, 0);       check("t4_ret1", addr, 32'h14);
    checkb("t4_empty", ras_empty, 1'b1);

    // RAS overflow: oldest dropped, fifth return falls back to alu_out
    do_reset();
    seq_step();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 0, 2'b01, 1, 0, 0, 32'h40);
      check("t5_call", addr, call_exp[i]);
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 0, 2'b11, 0, 1, 32'h301, 0);
      check("t5_ret", addr, ret_exp[i]);
    end
    checkb("t5_empty", ras_empty, 1'b1);

    // Address wrap
    jump_to(32'hFFFF_FFFC); check("t6_top", addr, 32'hFFFF_FFFC);
    seq_step(); check("t6_wrap", addr, 32'h0); checkb("t6_nomis", misaligned, 1'b0);

    // Misaligned target, held until async reset
    do_reset();
    seq_step();
    jump_to(32'h500);
    drive(0, 1, 0, 0, 2'b10, 1, 0, 32'h1002, 0);
    checkb("t7_mis", misaligned, 1'b1); check("t7_hold", addr, 32'h500);
    checkb("t7_no_push", ras_empty, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 2'b01, 1, 0, 0, 32'h40);
      check("t7_hold_more", addr, 32'h500);
    end
    do_reset();
    seq_step();

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      logic [31:0] r, a, im;
      if (m_mis || $urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        r = $urandom;
        case ($urandom_range(0, 3))
          0:       a = 32'd0;
          1:       a = r & ~32'd3;
          2:       a = (r & ~32'd3) | 32'd1;
          default: a = r;
        endcase
        if ($urandom_range(0, 15) == 0) im = $urandom;
        else im = {20'($urandom_range(0, 1) ? 20'hFFFFF : 20'h0), 10'($urandom_range(0, 1023)), 2'b00};
        drive($urandom_range(0, 4) == 0, $urandom_range(0, 4) != 0, $urandom_range(0, 3) == 0,
              1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, a, im);
      end
    end

    @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/module_pc_unit.md
# module_pc_unit

Parametrised successor to the single-width program counter: holds the fetch address, selects the next PC from sequential, PC-relative, register-indirect or predicted-return sources, and only advances when fetch is accepted and the pipeline is not stalled. Adds a configurable reset vector, a circular return-address stack (RAS), JALR target alignment and misaligned-target trapping. Sits between decode/ALU and instruction memory.

## Interface
- XLEN, 32, address/data width
- RESET_ADDR, 0, PC value loaded on reset
- RAS_DEPTH, 4, return-address-stack entries (power of two, ≥2)
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- stall  in  1  pipeline hold; PC and RAS frozen
- is_jmp  in  1  conditional-branch instruction; select derived from ALU result
- alu_not  in  1  branch taken when alu_out == 0 (else taken when alu_out != 0)
- is_branch  in  2  unconditional select (used when is_jmp = 0)
- is_call  in  1  current control transfer is a call; push link
- is_ret  in  1  current control transfer is a return; pop RAS
- alu_out  in  XLEN  ALU result / indirect target
- imm  in  XLEN  PC-relative offset
- imem_ready  in  1  instruction memory accepts addr this cycle
- addr  out  XLEN  current fetch address (registered)
- imem_valid  out  1  addr is a valid fetch request
- link  out  XLEN  addr + 4 (combinational)
- misaligned  out  1  sticky: target not 4-byte aligned
- ras_empty  out  1  RAS holds no entries

## Operation
- sel: is_jmp = 1 → {1'b0, taken}; else sel = is_branch.
- sel 00 → addr + 4; 01 → addr + imm; 10 → {alu_out[XLEN-1:1], 1'b0}; 11 → RAS top if !ras_empty, else {alu_out[XLEN-1:1], 1'b0}.
- All sums modulo 2^XLEN; wrap from 0xFFFF_FFFC + 4 → 0x0000_0000, no flag.
- advance = imem_valid & imem_ready & !stall & !misaligned. Without advance, addr, RAS and count hold; inputs are ignored.
- Misalignment: on advance, if next target bits[1:0] ≠ 00, addr holds, misaligned sets; cleared only by reset.
- RAS: circular buffer, pointer + count (0..RAS_DEPTH). Push (is_call & advance) writes link; when full, overwrites oldest, count saturates. Pop (is_ret & advance & !empty) decrements; pop when empty is a no-op. is_call & is_ret together: pop then push (top replaced by link, count unchanged unless empty, then 1).
- Push/pop are suppressed when the transfer is misaligned.

## Timing
- Reset (async assert): addr = RESET_ADDR, imem_valid = 0, misaligned = 0, RAS count = 0, ras_empty = 1. Contents of RAS need not be cleared.
- First rising edge after reset deassertion: imem_valid → 1, addr unchanged.
- Next address is combinational; appears on addr one edge after the advance cycle (1-cycle latency). RAS top used for sel 11 is the pre-edge value.
- Reset mid-operation overrides stall, handshake and pending pushes/pops in the same instant.
- Stall and !imem_ready are equivalent holds; addr stays stable until accepted.

## Structure
- Package pc_pkg: sel encodings PC_SEL_SEQ = 2'b00, PC_SEL_REL = 2'b01, PC_SEL_IND = 2'b10, PC_SEL_RET = 2'b11; instruction byte stride constant 4.
- One sub-module: return_address_stack (parameters XLEN, RAS_DEPTH; ports clock, reset, push, pop, push_data, top, empty).
- Next-PC select and misalignment check stay in module_pc_unit.

## Test plan
- Reset release, imem_ready = 1, sel 00 for 3 cycles, RESET_ADDR = 0x100 → addr 0x100, 0x100 (valid rises), 0x104, 0x108.
- is_jmp = 1, alu_not = 1, alu_out = 0, imm = 0x20 at addr 0x200 → addr 0x220; same with alu_out = 5 → 0x204.
- stall = 1 for 2 cycles then imem_ready = 0 for 1 cycle at addr 0x40 → addr stays 0x40 for 3 cycles, then 0x44.
- Call at 0x10 (sel 01, imm 0x100, is_call), call at 0x110 (imm 0x100, is_call), return (sel 11, is_ret) twice → addr 0x110, 0x210, 0x114, 0x14; ras_empty = 1 after.
- RAS_DEPTH = 4, 5 consecutive calls then 5 returns → first 4 returns pop newest-first; fifth uses alu_out with LSB cleared (alu_out 0x301 → 0x300).
- sel 10 with alu_out = 0x1002 → misaligned = 1, addr holds indefinitely; async reset mid-hold → addr = RESET_ADDR, misaligned = 0 immediately.
